// File: rtl/pc_trap_unit.sv
// pc_trap_unit: PC register, next-PC selection and trap controller for the
// single-cycle MIPS core. It handles edge-latched maskable interrupts, the
// undefined-instruction exception, EPC/cause capture and the kernel-mode guard.
module pc_trap_unit #(
   parameter int unsigned N_IRQ    = 4,
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] XADR     = 32'h8000_0008,
   parameter logic [31:0] IRQ_BASE = 32'h8000_0010
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic [2:0]       pc_src,
   input  logic             branch,
   input  logic [31:0]      conba,
   input  logic [25:0]      jt,
   input  logic [31:0]      data_a,
   input  logic             undef_ins,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             mask_wr,
   input  logic [N_IRQ-1:0] mask_din,
   input  logic             ack_wr,
   input  logic [N_IRQ-1:0] ack_din,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             kernel,
   output logic [31:0]      epc,
   output logic [7:0]       cause,
   output logic             trap,
   output logic [N_IRQ-1:0] irq_pending,
   output logic [N_IRQ-1:0] irq_mask
);

   localparam int unsigned CH_W = 3;

   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] ack_clr;
   logic [N_IRQ-1:0] req;
   logic [CH_W-1:0]  ch;
   logic             irq_take;
   logic             exc_take;
   logic [31:0]      irq_vec;
   logic [31:0]      pc_next;

   assign pc_plus4 = pc + 32'd4;
   assign kernel   = pc[31];
   assign rise     = irq_in & ~irq_q;
   assign ack_clr  = ack_wr ? ack_din : '0;
   assign req      = irq_pending & irq_mask;
   assign irq_take = ~kernel & ~stall & (|req);
   assign exc_take = ~kernel & ~stall & undef_ins & ~irq_take;
   assign trap     = irq_take | exc_take;
   assign irq_vec  = IRQ_BASE + {27'd0, ch, 2'b00};

   // Lowest-index enabled pending channel wins.
   always_comb begin
      ch = '0;
      for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
         if (req[i]) ch = CH_W'(i);
      end
   end

   // Next PC when no trap is taken; user code can never jump into kernel space.
   always_comb begin
      pc_next = pc_plus4;
      case (pc_src)
         3'd1:    pc_next = branch ? conba : pc_plus4;
         3'd2:    pc_next = {pc[31:28], jt, 2'b00};
         3'd3:    pc_next = kernel ? data_a : {1'b0, data_a[30:0]};
         3'd4:    pc_next = kernel ? {1'b0, epc[30:0]} : pc_plus4;
         default: pc_next = pc_plus4;
      endcase
   end

   // Edge capture, pending (set beats same-cycle ack) and mask registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_q       <= '0;
         irq_pending <= '0;
         irq_mask    <= '0;
      end else begin
         irq_q       <= irq_in;
         irq_pending <= (irq_pending & ~ack_clr) | rise;
         if (mask_wr) irq_mask <= mask_din;
      end
   end

   // PC, EPC and cause update: interrupt, then exception, then normal flow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         epc   <= '0;
         cause <= '0;
      end else if (irq_take) begin
         pc    <= irq_vec;
         epc   <= pc;
         cause <= {1'b1, 4'b0000, ch};
      end else if (exc_take) begin
         pc    <= XADR;
         epc   <= pc_plus4;
         cause <= 8'h00;
      end else if (!stall) begin
         pc    <= pc_next;
      end
   end

endmodule

// File: tb/tb_pc_trap_unit.sv
// Directed self-checking bench for pc_trap_unit.
module tb_pc_trap_unit;

   localparam int unsigned N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall;
   logic [2:0]    pc_src;
   logic          branch;
   logic [31:0]   conba;
   logic [25:0]   jt;
   logic [31:0]   data_a;
   logic          undef_ins;
   logic [N-1:0]  irq_in;
   logic          mask_wr;
   logic [N-1:0]  mask_din;
   logic          ack_wr;
   logic [N-1:0]  ack_din;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          kernel;
   logic [31:0]   epc;
   logic [7:0]    cause;
   logic          trap;
   logic [N-1:0]  irq_pending;
   logic [N-1:0]  irq_mask;

   int n_checks = 0;
   int n_pass   = 0;

   pc_trap_unit #(.N_IRQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pc_src(pc_src), .branch(branch),
      .conba(conba), .jt(jt), .data_a(data_a), .undef_ins(undef_ins),
      .irq_in(irq_in), .mask_wr(mask_wr), .mask_din(mask_din), .ack_wr(ack_wr),
      .ack_din(ack_din), .pc(pc), .pc_plus4(pc_plus4), .kernel(kernel), .epc(epc),
      .cause(cause), .trap(trap), .irq_pending(irq_pending), .irq_mask(irq_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_src = 3'd0; branch = 1'b0; conba = '0; jt = '0;
      data_a = '0; undef_ins = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_din = '0;
      ack_wr = 1'b0; ack_din = '0;
      tick();
      rst_n = 1'b1;
      check("rst_pc", pc, 32'h8000_0000);
      check("rst_pc4", pc_plus4, 32'h8000_0004);
      check("rst_kernel", 32'(kernel), 32'd1);
      check("rst_epc", epc, 32'd0);
      check("rst_cause", 32'(cause), 32'd0);
      check("rst_pend", 32'(irq_pending), 32'd0);
      check("rst_mask", 32'(irq_mask), 32'd0);
      tick(); check("seq1", pc, 32'h8000_0004);
      tick(); check("seq2", pc, 32'h8000_0008);

      // Kernel register jump into user space, then park at 0x100.
      pc_src = 3'd3; data_a = 32'h0000_0100;
      tick(); check("jr_user", pc, 32'h0000_0100);
      check("user_kernel", 32'(kernel), 32'd0);

      // Enable channels 1 and 2, pulse both.
      mask_wr = 1'b1; mask_din = 4'b0110;
      tick(); mask_wr = 1'b0;
      check("mask", 32'(irq_mask), 32'h6);
      check("pc_park", pc, 32'h0000_0100);
      irq_in = 4'b0110;
      tick(); irq_in = '0;
      check("pend_set", 32'(irq_pending), 32'h6);
      check("trap_irq", 32'(trap), 32'd1);
      tick();
      check("irq_pc", pc, 32'h8000_0014);
      check("irq_epc", epc, 32'h0000_0100);
      check("irq_cause", 32'(cause), 32'h81);
      check("irq_pend", 32'(irq_pending), 32'h6);
      check("kern_notrap", 32'(trap), 32'd0);

      // Ack channel 1 while it rises again: set wins.
      pc_src = 3'd0; ack_wr = 1'b1; ack_din = 4'b0010; irq_in = 4'b0010;
      tick(); ack_wr = 1'b0; irq_in = '0;
      check("ack_vs_set", 32'(irq_pending), 32'h6);
      check("kern_seq", pc, 32'h8000_0018);
      pc_src = 3'd4;
      tick(); check("eret", pc, 32'h0000_0100);
      pc_src = 3'd0;
      check("retrap", 32'(trap), 32'd1);
      tick(); check("retrap_pc", pc, 32'h8000_0014);
      check("retrap_epc", epc, 32'h0000_0100);
      ack_wr = 1'b1; ack_din = 4'b0110;
      tick(); ack_wr = 1'b0;
      check("ack_clr", 32'(irq_pending), 32'h0);

      // Undefined instruction at 0x200.
      pc_src = 3'd3; data_a = 32'h0000_0200;
      tick(); check("to_200", pc, 32'h0000_0200);
      pc_src = 3'd0; undef_ins = 1'b1; #1;
      check("trap_exc", 32'(trap), 32'd1);
      tick(); undef_ins = 1'b0;
      check("exc_pc", pc, 32'h8000_0008);
      check("exc_epc", epc, 32'h0000_0204);
      check("exc_cause", 32'(cause), 32'h00);

      // Undef together with pending channel 2: interrupt wins.
      pc_src = 3'd3; data_a = 32'h0000_0200; irq_in = 4'b0100;
      tick(); irq_in = '0;
      check("to_200b", pc, 32'h0000_0200);
      pc_src = 3'd0; undef_ins = 1'b1;
      tick(); undef_ins = 1'b0;
      check("pri_pc", pc, 32'h8000_0018);
      check("pri_cause", 32'(cause), 32'h82);
      check("pri_epc", epc, 32'h0000_0200);
      ack_wr = 1'b1; ack_din = 4'b0100;
      tick(); ack_wr = 1'b0;

      // Register jump guard.
      pc_src = 3'd3; data_a = 32'h0000_0100;
      tick();
      data_a = 32'h8000_0040;
      tick(); check("jr_guard", pc, 32'h0000_0040);
      pc_src = 3'd4;
      tick(); check("user_eret", pc, 32'h0000_0044);
      pc_src = 3'd0; undef_ins = 1'b1;
      tick(); undef_ins = 1'b0;
      check("exc2_pc", pc, 32'h8000_0008);
      pc_src = 3'd3; data_a = 32'h8000_0040;
      tick(); check("jr_kern", pc, 32'h8000_0040);

      // Jump from reset PC, then branch taken/not taken, then jump boundary.
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      pc_src = 3'd2; jt = 26'h10;
      tick(); check("jump", pc, 32'h8000_0040);
      pc_src = 3'd1; branch = 1'b0; conba = 32'h8000_1000;
      tick(); check("br_nt", pc, 32'h8000_0044);
      branch = 1'b1;
      tick(); check("br_t", pc, 32'h8000_1000);
      pc_src = 3'd2; jt = 26'h3FF_FFFF;
      tick(); check("jump_max", pc, 32'h8FFF_FFFC);
      pc_src = 3'd3; data_a = 32'hFFFF_FFFC;
      tick(); pc_src = 3'd7;
      tick(); check("wrap", pc, 32'h0000_0000);

      // Stall holds PC and blocks trap; pending still accumulates.
      mask_wr = 1'b1; mask_din = 4'b0001; pc_src = 3'd3; data_a = 32'h0000_0300;
      tick(); mask_wr = 1'b0;
      check("to_300", pc, 32'h0000_0300);
      stall = 1'b1; irq_in = 4'b0001;
      tick();
      check("stall_pend", 32'(irq_pending), 32'h1);
      check("stall_notrap", 32'(trap), 32'd0);
      check("stall_pc", pc, 32'h0000_0300);
      tick(); check("stall_pc2", pc, 32'h0000_0300);
      stall = 1'b0; #1;
      check("unstall_trap", 32'(trap), 32'd1);
      rst_n = 1'b0; irq_in = '0;
      tick(); rst_n = 1'b1;
      check("rst2_pc", pc, 32'h8000_0000);
      check("rst2_pend", 32'(irq_pending), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_trap_unit.md
Name: pc_trap_unit

Overview:
- Next-generation program-counter and trap controller for the single-cycle MIPS core.
- Owns the PC register and next-PC selection: sequential, branch, jump, register jump and ERET.
- Adds N_IRQ maskable, edge-latched interrupt channels with per-channel vectors, an EPC register, a cause register and a kernel-mode guard.
- Sits between the instruction decoder, which supplies pc_src, undef_ins and the jump/branch operands, and instruction ROM fetch.

Parameters:
- N_IRQ, 4, number of interrupt channels (1..8).
- RESET_PC, 32'h8000_0000, PC value after reset.
- XADR, 32'h8000_0008, undefined-instruction exception vector.
- IRQ_BASE, 32'h8000_0010, vector for channel 0; channel i vectors to IRQ_BASE + 4*i.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- stall  in  1  hold PC; no trap taken this cycle.
- pc_src  in  3  0 seq, 1 branch, 2 jump, 3 register jump, 4 eret; 5-7 treated as 0.
- branch  in  1  branch condition from ALU.
- conba  in  32  branch target.
- jt  in  26  jump target field.
- data_a  in  32  register-jump target.
- undef_ins  in  1  decoder flags an undefined instruction.
- irq_in  in  N_IRQ  level interrupt request lines.
- mask_wr  in  1  write mask register.
- mask_din  in  N_IRQ  new mask value.
- ack_wr  in  1  write-1-to-clear pending bits.
- ack_din  in  N_IRQ  pending bits to clear.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational.
- kernel  out  1  equals pc[31].
- epc  out  32  exception return address.
- cause  out  8  [7] 1=irq / 0=undef, [2:0] channel index.
- trap  out  1  combinational; high in the cycle a trap is taken.
- irq_pending  out  N_IRQ  pending register.
- irq_mask  out  N_IRQ  mask register; 1 = enabled.

Behaviour:
- Reset (rst_n=0 at clk edge, overrides everything):
  - pc=RESET_PC; epc=0; cause=0.
  - pending=0; mask=0; edge-detect history=0.
- Edge capture:
  - Register irq_q <= irq_in.
  - rise = irq_in & ~irq_q.
  - pending <= (pending & ~(ack_wr ? ack_din : 0)) | rise. Set wins over a same-cycle ack.
  - Pending updates continue during stall and in kernel mode.
- Mask: mask <= mask_din when mask_wr. The new mask takes effect from the next cycle.
- irq_take = ~kernel & ~stall & |(pending & mask). The channel is the lowest index set in pending & mask.
- exc_take = ~kernel & ~stall & undef_ins & ~irq_take. Interrupts have priority over the exception.
- In kernel mode (pc[31]=1), undef_ins and interrupts are ignored. Pending still accumulates.
- trap = irq_take | exc_take, combinational.
- On irq_take:
  - pc <= IRQ_BASE + 4*ch.
  - epc <= pc, so the interrupted instruction re-executes.
  - cause <= {1'b1, 4'b0, ch}.
  - Pending is not auto-cleared; software acks it.
- On exc_take:
  - pc <= XADR.
  - epc <= pc_plus4.
  - cause <= 8'h00.
- Otherwise, if stall, all of pc, epc and cause hold. Else pc updates by pc_src:
  - 0: pc+4.
  - 1: branch ? conba : pc+4.
  - 2: {pc[31:28], jt, 2'b00}.
  - 3: data_a, with bit 31 forced to 0 when kernel=0 (user code cannot enter kernel).
  - 4 eret: epc with bit 31 forced to 0. When kernel=0, eret acts as pc_src 0.
- Additions are 32-bit and wrap modulo 2^32, with no overflow flag.
- A trap in the cycle where pc_src selects jump/branch discards the jump; epc captures per the rules above.
- Latency:
  - Interrupt rise at edge k sets pending at edge k+1.
  - The earliest vector fetch is pc at edge k+2, if the channel is enabled and in user mode.

Test Plan:
- Reset, then pc_src=0 for 3 cycles → pc 8000_0000, 8000_0004, 8000_0008. Then register jump with data_a=0000_0100 → pc=0000_0100, kernel=0.
- User pc=0000_0100, mask=4'b0110, irq_in pulses on channels 1 and 2 in the same cycle → two edges later trap=1, pc=8000_0014, epc=0000_0100, cause=8'h81, pending=4'b0110.
- In kernel, ack_din=4'b0010 while irq_in[1] rises again in the same cycle → pending[1] stays 1. Eret → pc=0000_0100, then trap next cycle to 8000_0014.
- User pc=0000_0200, undef_ins=1 → pc=8000_0008, epc=0000_0204, cause=0. Repeat with a masked-in pending irq → irq wins, cause[7]=1.
- User register jump with data_a=8000_0040 → pc=0000_0040. Same from kernel → pc=8000_0040. Jump at pc=8000_0000 with jt=26'h10 → pc=8000_0040.
- stall=1 with a pending enabled irq → pc holds and trap=0. Release stall → trap=1. Assert rst_n=0 mid-trap → pc=RESET_PC and pending=0 next edge.
